// File: rtl/dma_pkg.sv
// Register map, AXI-Lite constants and FSM state encoding for the AXI DMA
// simple-mode configuration writer.
package dma_pkg;

  localparam logic [9:0]  REG_DMACR  = 10'h00;
  localparam logic [9:0]  REG_DMASR  = 10'h04;
  localparam logic [9:0]  REG_ADDR   = 10'h18;
  localparam logic [9:0]  REG_LEN    = 10'h28;

  localparam logic [9:0]  MM2S_BASE  = 10'h00;
  localparam logic [9:0]  S2MM_BASE  = 10'h30;

  localparam logic [31:0] DMACR_RS   = 32'h1;
  localparam logic [1:0]  BRESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_CR   = 3'd1,
    ST_WR_ADDR = 3'd2,
    ST_WR_LEN  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/dma_cfg_write_if.sv
// AXI-Lite write channel (AW/W/B) between the configuration writer and the
// DMA register slave.
interface dma_cfg_write_if;
  logic [9:0]  s_axi_lite_awaddr;
  logic        s_axi_lite_awvalid;
  logic        s_axi_lite_awready;
  logic [31:0] s_axi_lite_wdata;
  logic [3:0]  s_axi_lite_wstrb;
  logic        s_axi_lite_wvalid;
  logic        s_axi_lite_wready;
  logic [1:0]  s_axi_lite_bresp;
  logic        s_axi_lite_bvalid;
  logic        s_axi_lite_bready;

  modport master (
    output s_axi_lite_awaddr, s_axi_lite_awvalid, s_axi_lite_wdata,
           s_axi_lite_wstrb, s_axi_lite_wvalid, s_axi_lite_bready,
    input  s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_bresp,
           s_axi_lite_bvalid
  );

  modport slave (
    input  s_axi_lite_awaddr, s_axi_lite_awvalid, s_axi_lite_wdata,
           s_axi_lite_wstrb, s_axi_lite_wvalid, s_axi_lite_bready,
    output s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_bresp,
           s_axi_lite_bvalid
  );
endinterface

// File: rtl/axil_single_write.sv
// One AXI-Lite write: `go` loads address/data and raises AW/W/B together;
// `ok`/`fail` pulse on the accepted write response.
module axil_single_write
  import dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [9:0]  addr,
  input  logic [31:0] data,
  output logic        ok,
  output logic        fail,
  dma_cfg_write_if.master axil
);

  logic        awvalid_q, awvalid_d;
  logic        wvalid_q,  wvalid_d;
  logic        bready_q,  bready_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q,  w_done_d;
  logic [9:0]  awaddr_q,  awaddr_d;
  logic [31:0] wdata_q,   wdata_d;
  logic        b_fire;

  // The response is only taken once both address and data have been accepted.
  assign b_fire = axil.s_axi_lite_bvalid && bready_q && aw_done_q && w_done_q;
  assign ok     = b_fire && (axil.s_axi_lite_bresp == BRESP_OKAY);
  assign fail   = b_fire && (axil.s_axi_lite_bresp != BRESP_OKAY);

  always_comb begin
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    if (go) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      bready_d  = 1'b1;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      awaddr_d  = addr;
      wdata_d   = data;
    end else begin
      if (awvalid_q && axil.s_axi_lite_awready) begin
        awvalid_d = 1'b0;
        aw_done_d = 1'b1;
      end
      if (wvalid_q && axil.s_axi_lite_wready) begin
        wvalid_d = 1'b0;
        w_done_d = 1'b1;
      end
      if (b_fire) bready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign axil.s_axi_lite_awaddr  = awaddr_q;
  assign axil.s_axi_lite_awvalid = awvalid_q;
  assign axil.s_axi_lite_wdata   = wdata_q;
  assign axil.s_axi_lite_wstrb   = 4'hF;
  assign axil.s_axi_lite_wvalid  = wvalid_q;
  assign axil.s_axi_lite_bready  = bready_q;

endmodule

// File: rtl/dma_cfg_write.sv
// Programs one AXI DMA channel in simple mode: DMACR (RS=1), SA/DA, then
// LENGTH, which starts the transfer; `done` pulses after LENGTH is accepted.
module dma_cfg_write
  import dma_pkg::*;
#(
  parameter logic [9:0] CH_BASE = 10'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] cfg_addr,
  input  logic [25:0] cfg_len,
  output logic        busy,
  output logic        done,
  output logic        err,
  dma_cfg_write_if.master axil
);

  state_t      state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic [25:0] len_q,   len_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;
  logic        err_q,   err_d;
  logic        go;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ok, wr_fail;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    err_d   = 1'b0;
    go      = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_len != '0) begin
            addr_d  = cfg_addr;
            len_d   = cfg_len;
            state_d = ST_WR_CR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WR_CR:   if (wr_ok) state_d = ST_WR_ADDR; else if (wr_fail) state_d = ST_IDLE;
      ST_WR_ADDR: if (wr_ok) state_d = ST_WR_LEN;  else if (wr_fail) state_d = ST_IDLE;
      ST_WR_LEN:  if (wr_ok) state_d = ST_DONE;    else if (wr_fail) state_d = ST_IDLE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (wr_fail) err_d = 1'b1;

    // Launching on the transition edge lets valids rise in the first cycle of each write state.
    if (state_d != state_q) begin
      case (state_d)
        ST_WR_CR:   begin go = 1'b1; wr_addr = CH_BASE + REG_DMACR; wr_data = DMACR_RS;        end
        ST_WR_ADDR: begin go = 1'b1; wr_addr = CH_BASE + REG_ADDR;  wr_data = addr_q;          end
        ST_WR_LEN:  begin go = 1'b1; wr_addr = CH_BASE + REG_LEN;   wr_data = {6'b0, len_q};   end
        default:    go = 1'b0;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  axil_single_write u_wr (
    .clk  (clk),
    .rst  (rst),
    .go   (go),
    .addr (wr_addr),
    .data (wr_data),
    .ok   (wr_ok),
    .fail (wr_fail),
    .axil (axil)
  );

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_dma_cfg_write.sv
// Scoreboard bench for dma_cfg_write: MM2S and S2MM instances share one
// AXI-Lite slave model; writes and done/err pulses are checked against queues.
module tb_dma_cfg_write;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [31:0] cfg_addr = '0;
  logic [25:0] cfg_len = '0;
  logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic        sel = 1'b0;

  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [1:0]  bresp = 2'b00;

  dma_cfg_write_if ifa ();
  dma_cfg_write_if ifb ();

  assign ifa.s_axi_lite_awready = awready;
  assign ifa.s_axi_lite_wready  = wready;
  assign ifa.s_axi_lite_bvalid  = bvalid;
  assign ifa.s_axi_lite_bresp   = bresp;
  assign ifb.s_axi_lite_awready = awready;
  assign ifb.s_axi_lite_wready  = wready;
  assign ifb.s_axi_lite_bvalid  = bvalid;
  assign ifb.s_axi_lite_bresp   = bresp;

  dma_cfg_write #(.CH_BASE(10'h00)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
    .busy(busy_a), .done(done_a), .err(err_a), .axil(ifa)
  );
  dma_cfg_write #(.CH_BASE(10'h30)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
    .busy(busy_b), .done(done_b), .err(err_b), .axil(ifb)
  );

  logic [9:0]  awaddr_m;
  logic [31:0] wdata_m;
  logic        awvalid_m, wvalid_m, bready_m, busy_m, done_m, err_m;
  always_comb begin
    awaddr_m  = sel ? ifb.s_axi_lite_awaddr  : ifa.s_axi_lite_awaddr;
    wdata_m   = sel ? ifb.s_axi_lite_wdata   : ifa.s_axi_lite_wdata;
    awvalid_m = sel ? ifb.s_axi_lite_awvalid : ifa.s_axi_lite_awvalid;
    wvalid_m  = sel ? ifb.s_axi_lite_wvalid  : ifa.s_axi_lite_wvalid;
    bready_m  = sel ? ifb.s_axi_lite_bready  : ifa.s_axi_lite_bready;
    busy_m    = sel ? busy_b : busy_a;
    done_m    = sel ? done_b : done_a;
    err_m     = sel ? err_b  : err_a;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  wr_t exp_wr[$];
  int  exp_ev[$];
  int  rise_q[$];

  int cyc = 0, cyc0 = 0;
  always @(posedge clk) cyc++;

  // Slave model: capture handshakes on the rising edge, drive on the falling edge.
  logic        got_aw = 1'b0, got_w = 1'b0, b_taken = 1'b0;
  logic [9:0]  cap_a = '0;
  logic [31:0] cap_d = '0;
  int          aw_hs_cnt = 0, wr_idx = 0, err_idx = -1;
  int          aw_delay = 0, w_delay = 0, aw_cnt = 0, w_cnt = 0;
  wr_t         exp_item;

  always @(posedge clk) begin
    if (rst) begin
      got_aw  = 1'b0;
      got_w   = 1'b0;
      b_taken = 1'b0;
    end else begin
      if (awvalid_m && awready) begin got_aw = 1'b1; cap_a = awaddr_m; aw_hs_cnt++; end
      if (wvalid_m && wready)   begin got_w  = 1'b1; cap_d = wdata_m; end
      if (bvalid && bready_m) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write", 64'(cap_a), 64'h3FF);
        end else begin
          exp_item = exp_wr.pop_front();
          check("wr_addr", 64'(cap_a), 64'(exp_item.a));
          check("wr_data", 64'(cap_d), 64'(exp_item.d));
        end
        got_aw  = 1'b0;
        got_w   = 1'b0;
        b_taken = 1'b1;
        wr_idx++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      aw_cnt = 0; w_cnt = 0;
    end else begin
      if (awvalid_m) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
      else begin awready = 1'b0; aw_cnt = 0; end
      if (wvalid_m) begin wready = (w_cnt >= w_delay); w_cnt++; end
      else begin wready = 1'b0; w_cnt = 0; end
      if (b_taken) begin
        bvalid  = 1'b0;
        b_taken = 1'b0;
      end else if (got_aw && got_w && !bvalid) begin
        bvalid = 1'b1;
        bresp  = (wr_idx == err_idx) ? 2'b10 : 2'b00;
      end
    end
  end

  // Output monitor: done/err pulses, awvalid rise cycles, W-before-AW completion.
  logic prev_awv = 1'b0, saw_split = 1'b0;
  int   done_cyc = -1, done_total = 0, err_total = 0, ev_k = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (awvalid_m && !prev_awv) rise_q.push_back(cyc - cyc0);
      if (awvalid_m && !wvalid_m) saw_split = 1'b1;
      if (done_m || err_m) begin
        ev_k = (done_m ? EV_DONE : 0) + (err_m ? EV_ERR : 0);
        if (exp_ev.size() == 0) check("unexpected_event", 64'(ev_k), 64'd0);
        else                    check("event_kind", 64'(ev_k), 64'(exp_ev.pop_front()));
        if (done_m) begin done_cyc = cyc - cyc0; done_total++; end
        if (err_m) begin err_total++; check("busy_at_err", 64'(busy_m), 64'd0); end
      end
    end
    prev_awv = awvalid_m;
  end

  task automatic issue(input logic s, input logic [31:0] a, input logic [25:0] l);
    @(negedge clk);
    sel       = s;
    cfg_addr  = a;
    cfg_len   = l;
    rise_q.delete();
    aw_hs_cnt = 0;
    wr_idx    = 0;
    saw_split = 1'b0;
    done_cyc  = -1;
    cyc0      = cyc;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_idle(output int idle_cyc);
    idle_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy_m) begin idle_cyc = cyc - cyc0; break; end
    end
    if (idle_cyc < 0) check("idle_timeout", 64'd1, 64'd0);
  endtask

  int  ic;
  bit  found;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_awvalid", 64'(ifa.s_axi_lite_awvalid), 64'd0);
    check("rst_wvalid",  64'(ifa.s_axi_lite_wvalid),  64'd0);
    check("rst_bready",  64'(ifa.s_axi_lite_bready),  64'd0);
    check("rst_busy",    64'(busy_a), 64'd0);
    check("rst_done",    64'(done_a), 64'd0);
    check("rst_err",     64'(err_a),  64'd0);
    check("rst_awaddr",  64'(ifa.s_axi_lite_awaddr), 64'd0);
    check("rst_wdata",   64'(ifa.s_axi_lite_wdata),  64'd0);
    check("rst_wstrb",   64'(ifa.s_axi_lite_wstrb),  64'hF);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Best case on MM2S: writes in cycles 1,3,5, done in 7, idle in 8.
    exp_wr.push_back('{10'h000, 32'h0000_0001});
    exp_wr.push_back('{10'h018, 32'h1000_0000});
    exp_wr.push_back('{10'h028, 32'h0000_1000});
    exp_ev.push_back(EV_DONE);
    issue(1'b0, 32'h1000_0000, 26'd4096);
    wait_idle(ic);
    check("t1_idle_cycle", 64'(ic), 64'd8);
    check("t1_done_cycle", 64'(done_cyc), 64'd7);
    check("t1_rise_count", 64'(rise_q.size()), 64'd3);
    if (rise_q.size() == 3) begin
      check("t1_rise0", 64'(rise_q[0]), 64'd1);
      check("t1_rise1", 64'(rise_q[1]), 64'd3);
      check("t1_rise2", 64'(rise_q[2]), 64'd5);
    end
    check("t1_no_split", 64'(saw_split), 64'd0);
    check("t1_err_total", 64'(err_total), 64'd0);

    // S2MM with awready held off: W completes first.
    aw_delay = 3;
    exp_wr.push_back('{10'h030, 32'h0000_0001});
    exp_wr.push_back('{10'h048, 32'h2000_0040});
    exp_wr.push_back('{10'h058, 32'h0000_0100});
    exp_ev.push_back(EV_DONE);
    issue(1'b1, 32'h2000_0040, 26'd256);
    wait_idle(ic);
    check("t2_w_before_aw", 64'(saw_split), 64'd1);
    check("t2_aw_hs", 64'(aw_hs_cnt), 64'd3);
    aw_delay = 0;

    // SLVERR on the address write aborts before LENGTH.
    err_idx = 1;
    exp_wr.push_back('{10'h000, 32'h0000_0001});
    exp_wr.push_back('{10'h018, 32'h3000_0000});
    exp_ev.push_back(EV_ERR);
    issue(1'b0, 32'h3000_0000, 26'd64);
    wait_idle(ic);
    repeat (4) @(negedge clk);
    check("t3_rise_count", 64'(rise_q.size()), 64'd2);
    check("t3_no_done", 64'(done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    err_idx = -1;

    // Zero length is rejected without any bus activity.
    exp_ev.push_back(EV_ERR);
    issue(1'b0, 32'h4000_0000, 26'd0);
    repeat (5) @(negedge clk);
    check("t4_len0_rise", 64'(rise_q.size()), 64'd0);

    // Max length; a second start while busy must be ignored.
    exp_wr.push_back('{10'h000, 32'h0000_0001});
    exp_wr.push_back('{10'h018, 32'h0000_8000});
    exp_wr.push_back('{10'h028, 32'h03FF_FFFF});
    exp_ev.push_back(EV_DONE);
    issue(1'b0, 32'h0000_8000, 26'h3FF_FFFF);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_idle(ic);
    repeat (6) @(negedge clk);
    check("t4_single_seq", 64'(rise_q.size()), 64'd3);

    // Reset while the address write is pending, then replay from DMACR.
    aw_delay = 5;
    exp_wr.push_back('{10'h000, 32'h0000_0001});
    exp_wr.push_back('{10'h018, 32'h5000_0000});
    exp_wr.push_back('{10'h028, 32'h0000_0020});
    exp_ev.push_back(EV_DONE);
    issue(1'b0, 32'h5000_0000, 26'd32);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (awvalid_m && awaddr_m == 10'h018) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("t5_reach_wr_addr", 64'(found), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_awvalid", 64'(awvalid_m), 64'd0);
    check("t5_wvalid",  64'(wvalid_m),  64'd0);
    check("t5_bready",  64'(bready_m),  64'd0);
    check("t5_busy",    64'(busy_m),    64'd0);
    rst = 1'b0;
    exp_wr.delete();
    exp_ev.delete();
    aw_delay = 0;
    repeat (2) @(negedge clk);
    exp_wr.push_back('{10'h000, 32'h0000_0001});
    exp_wr.push_back('{10'h018, 32'h6000_0000});
    exp_wr.push_back('{10'h028, 32'h0000_0010});
    exp_ev.push_back(EV_DONE);
    issue(1'b0, 32'h6000_0000, 26'd16);
    wait_idle(ic);
    check("t5_replay_done", 64'(done_cyc), 64'd7);
    repeat (3) @(negedge clk);

    check("final_wr_queue", 64'(exp_wr.size()), 64'd0);
    check("final_ev_queue", 64'(exp_ev.size()), 64'd0);
    check("final_done_total", 64'(done_total), 64'd4);
    check("final_err_total", 64'(err_total), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/dma_cfg_write.md
# dma_cfg_write

Programs one Xilinx AXI DMA channel in simple (non-SG) mode over the AXI-Lite write channel: writes DMACR (run/stop), the source/destination address register, then LENGTH, which launches the transfer. It sits directly upstream of `dma_idle`. Its one-cycle `done` pulse drives `dma_idle.start`, and both share the DMA's AXI-Lite slave: this block owns AW/W/B, `dma_idle` owns AR/R.

## Interface
- `CH_BASE`, default 10'h00: channel register base. Use 10'h00 for MM2S (SA at +0x18) and 10'h30 for S2MM (DA at +0x18).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `cfg_addr`  in  32  buffer byte address; latched on accepted `start`.
- `cfg_len`  in  26  transfer length in bytes; latched on accepted `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the LENGTH write completes OKAY; feeds `dma_idle.start`.
- `err`  out  1  one-cycle pulse on a rejected request or a non-OKAY write response.
- `s_axi_lite_awaddr`  out  10; `s_axi_lite_awvalid`  out  1; `s_axi_lite_awready`  in  1.
- `s_axi_lite_wdata`  out  32; `s_axi_lite_wstrb`  out  4 (constant 4'hF); `s_axi_lite_wvalid`  out  1; `s_axi_lite_wready`  in  1.
- `s_axi_lite_bresp`  in  2; `s_axi_lite_bvalid`  in  1; `s_axi_lite_bready`  out  1.

## Operation
- States: IDLE, WR_CR, WR_ADDR, WR_LEN, DONE.
- IDLE, `start`=1, `cfg_len`≠0: latch the inputs and go to WR_CR.
- IDLE, `start`=1, `cfg_len`=0: pulse `err` for one cycle, stay in IDLE, issue no writes.
- `start` outside IDLE is ignored. It is not queued.
- Writes, in order:
  - WR_CR: awaddr = CH_BASE+0x00, wdata = 32'h0000_0001 (RS=1, interrupts off).
  - WR_ADDR: awaddr = CH_BASE+0x18, wdata = latched address.
  - WR_LEN: awaddr = CH_BASE+0x28, wdata = {6'b0, latched length}.
- Per write state:
  - awvalid, wvalid and bready are all asserted on the cycle the state is entered.
  - awvalid drops on the cycle after its own awready handshake; wvalid likewise on wready. AW and W may complete in either order or in the same cycle.
  - A per-write done flag is kept for each of AW and W.
  - On bvalid&&bready: bready drops. If bresp==2'b00, advance to the next state. Otherwise pulse `err`, go to IDLE, and issue no further writes.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- awaddr and wdata hold their last values while idle.

## Timing
- Reset values: awvalid, wvalid, bready, busy, done, err = 0; awaddr = 0; wdata = 0; state IDLE. wstrb is constant 4'hF.
- Reset mid-transaction drops all valids on the next edge and discards the latched request. The DMA is reset with the same `rst`.
- All outputs are registered. `start` sampled at edge 0 puts awvalid/wvalid high in cycle 1.
- Best case (ready tied high, bvalid one cycle after the AW/W handshake): 2 cycles per write. Writes issue in cycles 1, 3 and 5; `done` is high in cycle 7; `busy` is high in cycles 1–7; the next `start` is accepted in cycle 8.
- The B handshake is accepted only after both the AW and W handshakes have completed.
- awvalid/wvalid never deassert before their handshake. awaddr/wdata are stable while valid is high.

## Structure
- Shared package `dma_pkg`:
  - offsets DMACR=10'h00, DMASR=10'h04, ADDR=10'h18, LEN=10'h28; channel bases MM2S=10'h00, S2MM=10'h30.
  - DMACR_RS=32'h1, BRESP_OKAY=2'b00.
  - state enum.
- Sub-module `axil_single_write`: `go`, `addr`, `data` in; drives AW/W/B; returns `ok` and `fail` pulses. The top FSM only sequences the addresses and data.

## Test plan
- CH_BASE=0, ready tied high, bvalid 1 cycle late, start with addr 32'h1000_0000, len 26'd4096 -> writes (0x00, 0x1), (0x18, 0x1000_0000), (0x28, 0x1000) in that order; `done` in cycle 7; `err` never asserted.
- CH_BASE=10'h30, awready delayed 3 cycles, wready immediate -> addresses 0x30, 0x48, 0x58; wvalid drops before awvalid; no B accepted before the AW handshake.
- bresp=2'b10 on the ADDR write -> `err` pulses once; no LEN write; `done` stays 0; busy=0 on the following cycle.
- `cfg_len`=0 -> `err` pulse; awvalid stays 0; a second `start` issued while busy produces no second sequence.
- `rst` asserted while awvalid is high in WR_ADDR -> all valids 0 and busy 0 one edge later; a fresh `start` replays from WR_CR.
- Chained with `dma_idle`: `done` triggers status polling at 0x04, and the AR and AW channels never conflict.
